// File: rtl/day02_range_parser_if.sv
// ROM fetch port and parsed-range output port of the range parser.
// master = parser side, slave = ROM / downstream consumer side.
interface day02_range_parser_if #(
  parameter int N_ADDR_BITS = 16,
  parameter int VALUE_WIDTH = 64
);
  logic [N_ADDR_BITS:0]   rom_addr;
  logic [7:0]             rom_data;
  logic                   rom_valid;
  logic [VALUE_WIDTH-1:0] range_lo;
  logic [VALUE_WIDTH-1:0] range_hi;
  logic                   range_valid;
  logic                   range_ready;
  logic [15:0]            range_count;
  logic                   parse_error;
  logic                   done;

  modport master (
    output rom_addr,
    input  rom_data,
    input  rom_valid,
    output range_lo,
    output range_hi,
    output range_valid,
    input  range_ready,
    output range_count,
    output parse_error,
    output done
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output rom_valid,
    input  range_lo,
    input  range_hi,
    input  range_valid,
    output range_ready,
    input  range_count,
    input  parse_error,
    input  done
  );
endinterface

// File: rtl/day02_range_parser.sv
// Streams ASCII "lo-hi" pairs from a byte ROM (2 cycles/byte) and emits each range with valid/ready.
// EMIT holds the range until range_ready; parsing stalls meanwhile. done is sticky until reset.
module day02_range_parser #(
  parameter int N_ADDR_BITS = 16,
  parameter int VALUE_WIDTH = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  day02_range_parser_if.master bus
);
  localparam int AW = N_ADDR_BITS + 1;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CONSUME = 2'd1,
    EMIT    = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t                 state;
  logic [AW-1:0]          addr;
  logic [VALUE_WIDTH-1:0] acc;
  logic [VALUE_WIDTH-1:0] lo_q;
  logic                   field_hi;
  logic                   seen_digit;
  logic                   eof_pending;
  logic [VALUE_WIDTH-1:0] out_lo;
  logic [VALUE_WIDTH-1:0] out_hi;
  logic                   out_valid;
  logic [15:0]            count;
  logic                   err;
  logic                   done_q;

  logic                   is_digit;
  logic                   is_dash;
  logic                   is_sep;
  logic                   is_skip;
  logic                   at_eof;
  logic                   term_emit;
  logic                   term_empty;
  logic [VALUE_WIDTH-1:0] acc_next;

  always_comb begin
    is_digit   = (bus.rom_data >= 8'h30) && (bus.rom_data <= 8'h39);
    is_dash    = (bus.rom_data == 8'h2d);
    is_sep     = (bus.rom_data == 8'h2c) || (bus.rom_data == 8'h0a);
    is_skip    = (bus.rom_data == 8'h20) || (bus.rom_data == 8'h0d);
    // The last addressable byte is treated as end of file so the address never wraps.
    at_eof     = !bus.rom_valid || (addr == {AW{1'b1}});
    term_emit  = field_hi && seen_digit;
    term_empty = !field_hi && !seen_digit;
    // ASCII '0'..'9' carry their value in the low nibble.
    acc_next   = (acc << 3) + (acc << 1) + VALUE_WIDTH'(bus.rom_data[3:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      addr        <= '0;
      acc         <= '0;
      lo_q        <= '0;
      field_hi    <= 1'b0;
      seen_digit  <= 1'b0;
      eof_pending <= 1'b0;
      out_lo      <= '0;
      out_hi      <= '0;
      out_valid   <= 1'b0;
      count       <= '0;
      err         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          state <= CONSUME;
        end

        CONSUME: begin
          if (!at_eof) begin
            addr <= addr + 1'b1;
          end
          if (at_eof || is_sep) begin
            acc        <= '0;
            seen_digit <= 1'b0;
            field_hi   <= 1'b0;
            if (term_emit) begin
              out_lo      <= lo_q;
              out_hi      <= acc;
              out_valid   <= 1'b1;
              eof_pending <= at_eof;
              state       <= EMIT;
            end else begin
              if (!term_empty) begin
                err <= 1'b1;
              end
              if (at_eof) begin
                done_q <= 1'b1;
                state  <= FINISH;
              end else begin
                state  <= FETCH;
              end
            end
          end else if (is_digit) begin
            acc        <= acc_next;
            seen_digit <= 1'b1;
            state      <= FETCH;
          end else if (is_dash && !field_hi && seen_digit) begin
            lo_q       <= acc;
            acc        <= '0;
            seen_digit <= 1'b0;
            field_hi   <= 1'b1;
            state      <= FETCH;
          end else if (is_skip) begin
            state <= FETCH;
          end else begin
            // Misplaced '-' or an unexpected byte: drop the partial range and restart.
            err        <= 1'b1;
            acc        <= '0;
            seen_digit <= 1'b0;
            field_hi   <= 1'b0;
            state      <= FETCH;
          end
        end

        EMIT: begin
          if (bus.range_ready) begin
            out_valid <= 1'b0;
            count     <= count + 16'd1;
            if (eof_pending) begin
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              state  <= FETCH;
            end
          end
        end

        FINISH: begin
          done_q <= 1'b1;
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.rom_addr    = addr;
  assign bus.range_lo    = out_lo;
  assign bus.range_hi    = out_hi;
  assign bus.range_valid = out_valid;
  assign bus.range_count = count;
  assign bus.parse_error = err;
  assign bus.done        = done_q;
endmodule
